jump_encoder: RTL and testbench

- Inverse of the processor's jump-target path: takes a current PC and a desired absolute jump target and encodes a MIPS J or JAL instruction word.
- Also flags targets that the jump path cannot reach.
- Used by the in-fabric program loader / self-test sequencer to build jump instructions before they are written into instruction memory.
- Two-stage valid/ready pipeline, with full throughput and backpressure.

---
 rtl/jump_encoder.sv | 152 +++++++++++++++
 tb/tb_jump_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_encoder.sv
// jump_encoder: builds MIPS J/JAL instruction words from a PC and an absolute
// jump target, flagging targets the 26-bit jump field cannot reach.
// Two-stage valid/ready pipeline: S1 captures the request and evaluates
// reachability, S2 holds the encoded word presented to the consumer.
module jump_encoder #(
  parameter logic [5:0]  OPC_J   = 6'b000010,
  parameter logic [5:0]  OPC_JAL = 6'b000011,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_target,
  input  logic             in_link,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [1:0]       out_err_code,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Only the region nibble of the PC matters; the rest never leaves the port.
  logic unused_pc_low;
  assign unused_pc_low = ^in_pc[27:0];

  // Stage 1 registers
  logic        s1_valid_q,  s1_valid_d;
  logic [3:0]  s1_region_q, s1_region_d;
  logic [31:0] s1_target_q, s1_target_d;
  logic        s1_link_q,   s1_link_d;

  // Stage 2 (output) registers
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q,   s2_err_d;
  logic [1:0]  s2_code_q,  s2_code_d;

  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Handshake / advance signals
  logic in_fire;
  logic out_fire;
  logic s1_advance;

  // S1 reachability results
  logic        s1_region_err;
  logic        s1_align_err;
  logic [5:0]  s1_opcode;
  logic [31:0] s1_instr;

  // Handshakes: S2 frees up when empty or draining, S1 moves when S2 can take it.
  always_comb begin
    out_fire   = s2_valid_q && out_ready;
    s1_advance = s1_valid_q && (!s2_valid_q || out_fire);
    in_ready   = !s1_valid_q || s1_advance;
    in_fire    = in_valid && in_ready;
  end

  // S1 evaluation: region must match the PC nibble, target must be word aligned.
  always_comb begin
    s1_region_err = (s1_target_q[31:28] != s1_region_q);
    s1_align_err  = (s1_target_q[1:0] != 2'b00);
    s1_opcode     = s1_link_q ? OPC_JAL : OPC_J;
    s1_instr      = {s1_opcode, s1_target_q[27:2]};
  end

  // S1 next state: refill from the input whenever the slot is free or moving on.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_region_d = s1_region_q;
    s1_target_d = s1_target_q;
    s1_link_d   = s1_link_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_fire) begin
      s1_region_d = in_pc[31:28];
      s1_target_d = in_target;
      s1_link_d   = in_link;
    end
  end

  // S2 next state: load from S1 on advance, otherwise empty out after a transfer.
  // Data is left untouched when the slot empties so a stalled word never changes.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    s2_code_d  = s2_code_q;
    if (s1_advance) begin
      s2_valid_d = 1'b1;
      s2_instr_d = s1_instr;
      s2_code_d  = {s1_align_err, s1_region_err};
      s2_err_d   = s1_align_err || s1_region_err;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  // Error counter: counts delivered erroneous results, sticks at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (out_fire && s2_err_q && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_ONE;
    end
  end

  // Stage 1 register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_region_q <= 4'h0;
      s1_target_q <= 32'h0;
      s1_link_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_region_q <= s1_region_d;
      s1_target_q <= s1_target_d;
      s1_link_q   <= s1_link_d;
    end
  end

  // Stage 2 register and error counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= 32'h0;
      s2_err_q    <= 1'b0;
      s2_code_q   <= 2'b00;
      err_count_q <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      s2_code_q   <= s2_code_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_instr    = s2_instr_q;
  assign out_err      = s2_err_q;
  assign out_err_code = s2_code_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_jump_encoder.sv
// Self-checking bench for jump_encoder: table vectors with latency checks,
// backpressure, full-rate random streaming, mid-flight reset and counter
// saturation on a narrow-counter instance. Results go through a scoreboard.
module tb_jump_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_link;
  logic [31:0] in_pc, in_target;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_instr;
  logic [1:0]  out_err_code;
  logic [15:0] err_count;

  logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_err_s;
  logic [31:0] out_instr_s;
  logic [1:0]  out_err_code_s;
  logic [3:0]  err_count_s;

  always #5 clk = ~clk;

  jump_encoder u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_target(in_target), .in_link(in_link),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .out_err_code(out_err_code), .err_count(err_count)
  );

  jump_encoder #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_s), .in_ready(in_ready_s), .in_pc(32'h0000_0000),
    .in_target(32'h2000_0000), .in_link(1'b0),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_instr(out_instr_s),
    .out_err(out_err_s), .out_err_code(out_err_code_s), .err_count(err_count_s)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        lnk;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  vec_t        tbl [6];
  vec_t        sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc = 0;
  int          n_out = 0;
  int          n_stall = 0;
  logic [15:0] exp_cnt = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder used for generated stimulus.
  function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] tgt, input logic lnk);
    vec_t v;
    v.pc    = pc;
    v.tgt   = tgt;
    v.lnk   = lnk;
    v.instr = {(lnk ? 6'b000011 : 6'b000010), tgt[27:2]};
    v.code  = {tgt[1:0] != 2'b00, tgt[31:28] != pc[31:28]};
    v.err   = (v.code != 2'b00);
    return v;
  endfunction

  // Present one request; push its expectation when the DUT accepts it.
  task automatic send(input vec_t v);
    bit got = 0;
    in_valid  = 1'b1;
    in_pc     = v.pc;
    in_target = v.tgt;
    in_link   = v.lnk;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        sb_q.push_back(v);
        n_acc++;
        if (i != 0) n_stall++;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready never rose for target 0x%08h", v.tgt);
    end
  endtask

  // Output monitor: every transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got 0x%08h with empty scoreboard", out_instr);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_err", {31'h0, out_err}, {31'h0, e.err});
        chk("out_err_code", {30'h0, out_err_code}, {30'h0, e.code});
        chk("err_count_run", {16'h0, err_count}, {16'h0, exp_cnt});
        if (e.code == 2'b00)
          chk("round_trip", {e.pc[31:28], out_instr[25:0], 2'b00}, e.tgt);
        if (e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
      end
    end
  end

  initial begin
    vec_t bp [5];
    int   acc0, out0, acc_s, out_s;

    tbl[0] = '{32'h0040_0018, 32'h0040_0100, 1'b0, 32'h0810_0040, 1'b0, 2'b00};
    tbl[1] = '{32'h1000_0000, 32'h1FFF_FFFC, 1'b1, 32'h0FFF_FFFF, 1'b0, 2'b00};
    tbl[2] = '{32'h0040_0000, 32'h2000_0000, 1'b0, 32'h0800_0000, 1'b1, 2'b01};
    tbl[3] = '{32'h0040_0000, 32'h0040_0102, 1'b0, 32'h0810_0040, 1'b1, 2'b10};
    tbl[4] = '{32'h0040_0000, 32'h3000_0003, 1'b0, 32'h0800_0000, 1'b1, 2'b11};
    tbl[5] = '{32'hF000_0000, 32'hF000_0004, 1'b1, 32'h0C00_0001, 1'b0, 2'b00};

    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_target = '0; in_link = 1'b0;
    out_ready = 1'b0; in_valid_s = 1'b0; out_ready_s = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    chk("rst_err_code", {30'h0, out_err_code}, 32'h0);
    chk("rst_err_count", {16'h0, err_count}, 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Table vectors, one at a time, checking the two-cycle latency.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i]);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_not_early", {31'h0, out_valid}, 32'h0);
      @(negedge clk);
      chk("lat_valid_n2", {31'h0, out_valid}, 32'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("err_count_after_tbl", {16'h0, err_count}, 32'd3);
    @(posedge clk); #1;

    // Backpressure: five back-to-back requests with the consumer stalled 4 cycles.
    for (int k = 0; k < 5; k++)
      bp[k] = mk(32'h0040_0000, 32'h0040_0000 + 32'(k * 4 + 8), k[0]);
    acc0 = n_acc;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) send(bp[k]);
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
          chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
          chk("bp_hold_instr", out_instr, bp[0].instr);
        end
        chk("bp_accepts", n_acc - acc0, 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_no_gap", {31'h0, out_valid}, 32'h1);
        end
      end
    join
    @(posedge clk); #1;

    // Full-rate random streaming.
    n_stall = 0;
    out0 = n_out;
    for (int k = 0; k < 100; k++) begin
      logic [31:0] pc, tgt;
      pc  = $urandom;
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt = {pc[31:28], tgt[27:2], 2'b00};
      send(mk(pc, tgt, 1'($urandom_range(0, 1))));
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("stream_no_stall", n_stall, 32'd0);
    chk("stream_out_count", n_out - out0, 32'd100);
    @(posedge clk); #1;

    // Reset with two requests in flight.
    out_ready = 1'b0;
    send(mk(32'h0040_0000, 32'h2000_0000, 1'b0));
    send(mk(32'h0040_0000, 32'h0040_0040, 1'b1));
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    exp_cnt = 16'h0;
    @(negedge clk);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_err_count", {16'h0, err_count}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("midrst_out_instr", out_instr, 32'h0);
    out_ready = 1'b1;
    out0 = n_out;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale", n_out - out0, 32'd0);
    @(posedge clk); #1;

    // Saturation on the 4-bit counter instance: 20 errors must stick at 15.
    acc_s = 0; out_s = 0;
    in_valid_s = 1'b1;
    for (int c = 0; c < 200 && out_s < 20; c++) begin
      @(negedge clk);
      if (in_valid_s && in_ready_s) acc_s++;
      if (out_valid_s && out_ready_s) out_s++;
      @(posedge clk); #1;
      if (acc_s >= 20) in_valid_s = 1'b0;
    end
    @(negedge clk);
    chk("sat_out_count", out_s, 32'd20);
    chk("sat_err_count", {28'h0, err_count_s}, 32'd15);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
